// File: rtl/ac97_record_capture.sv
// ac97_record_capture: receive side of the AC97 codec path.
// Captures one left/right record sample pair per codec frame into a small first-word
// fall-through FIFO. A valid/ready interface drains the FIFO. A 4-bit peak meter drives
// the LEDs.
//
// Optional feature macro: RECORD_MONO_MIX_EN. When it is defined, both stored channels
// and the peak meter use (left + right) >>> 1.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   new_frame      one-cycle strobe per codec frame (PCM_Playback_Accept)
//   record_left    signed left record sample, valid with new_frame
//   record_right   signed right record sample, valid with new_frame
//   enable         capture enable (level)
//   out_left       head-of-FIFO left sample
//   out_right      head-of-FIFO right sample
//   out_valid      FIFO not empty
//   out_ready      consumer accepts the head entry
//   fill           current entry count
//   overflow       sticky: a captured frame was dropped
//   clear_overflow synchronous clear of overflow (a drop in the same cycle wins)
//   level          peak meter, bits [14:11] of the window peak magnitude
module ac97_record_capture #(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned PEAK_WINDOW = 4800
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  new_frame,
  input  logic [15:0]           record_left,
  input  logic [15:0]           record_right,
  input  logic                  enable,
  output logic [15:0]           out_left,
  output logic [15:0]           out_right,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   fill,
  output logic                  overflow,
  input  logic                  clear_overflow,
  output logic [3:0]            level
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned WinW  = $clog2(PEAK_WINDOW);

  localparam logic [DEPTH_LOG2:0] FillFull = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [WinW-1:0]     WinLast  = WinW'(PEAK_WINDOW - 1);

  typedef enum logic [1:0] {StIdle, StArm, StCapture} state_e;

  state_e state_q, state_d;

  logic [31:0]           mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   fill_q, fill_d;
  logic                  overflow_q, overflow_d;
  logic [14:0]           peak_q, peak_d;
  logic [WinW-1:0]       win_q, win_d;
  logic [3:0]            level_q, level_d;

  logic        capture;
  logic        pop;
  logic        push;
  logic        drop;
  logic [15:0] store_left, store_right;
  logic [15:0] meter_sample;
  logic [14:0] magnitude;
  logic [14:0] peak_max;

  // Frame selection: capture only starts on a frame boundary seen in StArm.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StArm;
      end
      StArm: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (new_frame) begin
          capture = 1'b1;
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (new_frame) begin
          capture = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef RECORD_MONO_MIX_EN
  logic [16:0] mix_sum;
  always_comb begin
    mix_sum     = {record_left[15], record_left} + {record_right[15], record_right};
    store_left  = mix_sum[16:1];
    store_right = mix_sum[16:1];
  end
`else
  always_comb begin
    store_left  = record_left;
    store_right = record_right;
  end
`endif

  assign meter_sample = store_left;

  // Magnitude with -32768 saturated so that it fits in 15 bits.
  always_comb begin
    if (!meter_sample[15]) begin
      magnitude = meter_sample[14:0];
    end else if (meter_sample == 16'h8000) begin
      magnitude = 15'h7fff;
    end else begin
      magnitude = 15'(-meter_sample);
    end
    peak_max = (magnitude > peak_q) ? magnitude : peak_q;
  end

  assign out_valid = (fill_q != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = capture && ((fill_q != FillFull) || pop);
  assign drop      = capture && !push;

  always_comb begin
    fill_d = fill_q;
    if (push && !pop) begin
      fill_d = fill_q + 1'b1;
    end else if (pop && !push) begin
      fill_d = fill_q - 1'b1;
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // The meter counts every capture frame, including dropped ones.
  always_comb begin
    peak_d  = peak_q;
    win_d   = win_q;
    level_d = level_q;
    if (capture) begin
      if (win_q == WinLast) begin
        level_d = peak_max[14:11];
        peak_d  = '0;
        win_d   = '0;
      end else begin
        peak_d = peak_max;
        win_d  = win_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      peak_q     <= '0;
      win_q      <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
      peak_q     <= peak_d;
      win_q      <= win_d;
      level_q    <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage is cleared on reset so the outputs read zero until the first push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= {store_left, store_right};
    end
  end

  assign out_left  = mem_q[rd_ptr_q][31:16];
  assign out_right = mem_q[rd_ptr_q][15:0];
  assign fill      = fill_q;
  assign overflow  = overflow_q;
  assign level     = level_q;

endmodule
